// File: rtl/match_motion_collect_pkg.sv
// Shared widths, defaults and types for the match displacement collector.
package match_motion_collect_pkg;

  localparam int unsigned COOR_W    = 10;
  localparam int unsigned DISP_W    = 11;
  localparam int unsigned SUMW_DEF  = 20;
  localparam int unsigned CNTW_DEF  = 10;
  localparam int unsigned DEPTH_DEF = 64;
  localparam logic [COOR_W-1:0] MAX_DISP_DEF = 10'd200;

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_REPORT = 1'b1
  } state_e;

  typedef struct packed {
    logic [COOR_W-1:0] dst_x;
    logic [COOR_W-1:0] dst_y;
    logic [DISP_W-1:0] dx;
    logic [DISP_W-1:0] dy;
  } match_entry_t;

  // Signed displacement dst - src, one extra bit so the full range fits.
  function automatic logic signed [DISP_W-1:0] disp(input logic [COOR_W-1:0] a_dst,
                                                     input logic [COOR_W-1:0] a_src);
    return {1'b0, a_dst} - {1'b0, a_src};
  endfunction

endpackage

// File: rtl/match_motion_collect_if.sv
// Matcher input stream, buffered match output and batch summary of the collector.
interface match_motion_collect_if
  import match_motion_collect_pkg::*;
#(
  parameter int unsigned SUMW = SUMW_DEF,
  parameter int unsigned CNTW = CNTW_DEF
);
  logic              i_valid;
  logic [COOR_W-1:0] i_src_coor_x;
  logic [COOR_W-1:0] i_src_coor_y;
  logic [COOR_W-1:0] i_dst_coor_x;
  logic [COOR_W-1:0] i_dst_coor_y;
  logic              i_end;
  logic              o_m_valid;
  logic              i_m_ready;
  logic [COOR_W-1:0] o_m_dst_x;
  logic [COOR_W-1:0] o_m_dst_y;
  logic [DISP_W-1:0] o_m_dx;
  logic [DISP_W-1:0] o_m_dy;
  logic              o_stat_valid;
  logic [SUMW-1:0]   o_sum_dx;
  logic [SUMW-1:0]   o_sum_dy;
  logic [CNTW-1:0]   o_count;
  logic [CNTW-1:0]   o_drop;

  modport master (
    output i_valid, i_src_coor_x, i_src_coor_y, i_dst_coor_x, i_dst_coor_y, i_end, i_m_ready,
    input  o_m_valid, o_m_dst_x, o_m_dst_y, o_m_dx, o_m_dy,
    input  o_stat_valid, o_sum_dx, o_sum_dy, o_count, o_drop
  );

  modport slave (
    input  i_valid, i_src_coor_x, i_src_coor_y, i_dst_coor_x, i_dst_coor_y, i_end, i_m_ready,
    output o_m_valid, o_m_dst_x, o_m_dst_y, o_m_dx, o_m_dy,
    output o_stat_valid, o_sum_dx, o_sum_dy, o_count, o_drop
  );
endinterface

// File: rtl/match_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is taken when a pop happens the same cycle.
module match_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = i_pop && !o_empty;
  assign push_ok = i_push && (!o_full || pop_ok);
  assign o_rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; pointers alone define occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && push_ok) mem[wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/match_motion_collect.sv
// Displacement/outlier filter on matched keypoint pairs, match FIFO and per-batch statistics.
module match_motion_collect
  import match_motion_collect_pkg::*;
#(
  parameter int unsigned       DEPTH    = DEPTH_DEF,
  parameter logic [COOR_W-1:0] MAX_DISP = MAX_DISP_DEF,
  parameter int unsigned       SUMW     = SUMW_DEF,
  parameter int unsigned       CNTW     = CNTW_DEF
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  match_motion_collect_if.slave bus
);
  logic signed [DISP_W-1:0] dx_c, dy_c, limit_c;
  logic                     accept_c, pop_c, push_c, drop_c;
  logic                     fifo_full, fifo_empty;
  match_entry_t             wr_entry, head;
  logic [SUMW-1:0]          sum_dx, sum_dy, sum_dx_nxt, sum_dy_nxt;
  logic [CNTW-1:0]          cnt, drop, cnt_nxt, drop_nxt;
  logic [SUMW-1:0]          stat_sum_dx, stat_sum_dy;
  logic [CNTW-1:0]          stat_cnt, stat_drop;
  state_e                   state_q, state_d;
  logic                     stat_valid_c;

  assign dx_c     = disp(bus.i_dst_coor_x, bus.i_src_coor_x);
  assign dy_c     = disp(bus.i_dst_coor_y, bus.i_src_coor_y);
  assign limit_c  = $signed({1'b0, MAX_DISP});
  assign accept_c = bus.i_valid && (dx_c <= limit_c) && (dx_c >= -limit_c)
                                && (dy_c <= limit_c) && (dy_c >= -limit_c);

  assign pop_c  = !fifo_empty && bus.i_m_ready;
  assign push_c = accept_c && (!fifo_full || pop_c);
  assign drop_c = accept_c && !push_c;

  assign wr_entry = '{dst_x: bus.i_dst_coor_x, dst_y: bus.i_dst_coor_y,
                      dx: dx_c, dy: dy_c};

  match_sync_fifo #(
    .WIDTH ($bits(match_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push_c),
    .i_wdata (wr_entry),
    .i_pop   (pop_c),
    .o_rdata (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign bus.o_m_valid = !fifo_empty;
  assign bus.o_m_dst_x = head.dst_x;
  assign bus.o_m_dst_y = head.dst_y;
  assign bus.o_m_dx    = head.dx;
  assign bus.o_m_dy    = head.dy;

  // Batch values including this cycle's pair, so a pair coincident with i_end closes with the batch.
  always_comb begin
    sum_dx_nxt = sum_dx;
    sum_dy_nxt = sum_dy;
    cnt_nxt    = cnt;
    drop_nxt   = drop;
    if (accept_c) begin
      sum_dx_nxt = sum_dx + {{(SUMW-DISP_W){dx_c[DISP_W-1]}}, dx_c};
      sum_dy_nxt = sum_dy + {{(SUMW-DISP_W){dy_c[DISP_W-1]}}, dy_c};
      if (cnt != '1) cnt_nxt = cnt + CNTW'(1);
    end
    if (drop_c && (drop != '1)) drop_nxt = drop + CNTW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sum_dx      <= '0;
      sum_dy      <= '0;
      cnt         <= '0;
      drop        <= '0;
      stat_sum_dx <= '0;
      stat_sum_dy <= '0;
      stat_cnt    <= '0;
      stat_drop   <= '0;
    end else if (bus.i_end) begin
      stat_sum_dx <= sum_dx_nxt;
      stat_sum_dy <= sum_dy_nxt;
      stat_cnt    <= cnt_nxt;
      stat_drop   <= drop_nxt;
      sum_dx      <= '0;
      sum_dy      <= '0;
      cnt         <= '0;
      drop        <= '0;
    end else begin
      sum_dx <= sum_dx_nxt;
      sum_dy <= sum_dy_nxt;
      cnt    <= cnt_nxt;
      drop   <= drop_nxt;
    end
  end

  assign bus.o_sum_dx = stat_sum_dx;
  assign bus.o_sum_dy = stat_sum_dy;
  assign bus.o_count  = stat_cnt;
  assign bus.o_drop   = stat_drop;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_ACCUM;
    else          state_q <= state_d;
  end

  // An i_end seen in REPORT starts another close immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM:  if (bus.i_end) state_d = ST_REPORT;
      ST_REPORT: state_d = bus.i_end ? ST_REPORT : ST_ACCUM;
      default:   state_d = ST_ACCUM;
    endcase
  end

  always_comb begin
    stat_valid_c = 1'b0;
    if (state_q == ST_REPORT) stat_valid_c = 1'b1;
  end

  assign bus.o_stat_valid = stat_valid_c;

endmodule

// File: tb/tb_match_motion_collect.sv
// Self-checking bench for match_motion_collect: scoreboard model plus vector table and corner sequences.
module tb_match_motion_collect;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  match_motion_collect_if #(.SUMW(20), .CNTW(10)) bus ();

  match_motion_collect #(
    .DEPTH(64), .MAX_DISP(10'd200), .SUMW(20), .CNTW(10)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  typedef struct { int x; int y; int dx; int dy; } ent_t;
  typedef struct { int sx; int sy; int tx; int ty; int edx; int edy; bit acc; } vec_t;

  ent_t q[$];
  int total = 0;
  int bad = 0;
  int acc_dx = 0, acc_dy = 0, acc_cnt = 0, acc_drop = 0;
  int held_dx = 0, held_dy = 0, held_cnt = 0, held_drop = 0;
  bit pend = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: compare visible DUT state against the model, drive inputs, advance model and clock.
  task automatic tick(input bit v, input int sx, input int sy, input int tx, input int ty,
                      input bit e, input bit rdy);
    int mdx, mdy;
    bit acc, pop;
    ent_t ent;
    chk("m_valid", int'(bus.o_m_valid), int'(q.size() != 0));
    if (q.size() != 0) begin
      chk("head_x", int'(bus.o_m_dst_x), q[0].x);
      chk("head_y", int'(bus.o_m_dst_y), q[0].y);
      chk("head_dx", int'($signed(bus.o_m_dx)), q[0].dx);
      chk("head_dy", int'($signed(bus.o_m_dy)), q[0].dy);
    end
    chk("stat_valid", int'(bus.o_stat_valid), int'(pend));
    chk("sum_dx", int'($signed(bus.o_sum_dx)), held_dx);
    chk("sum_dy", int'($signed(bus.o_sum_dy)), held_dy);
    chk("count", int'(bus.o_count), held_cnt);
    chk("drop", int'(bus.o_drop), held_drop);
    pend = 0;

    bus.i_valid      = v;
    bus.i_src_coor_x = 10'(sx);
    bus.i_src_coor_y = 10'(sy);
    bus.i_dst_coor_x = 10'(tx);
    bus.i_dst_coor_y = 10'(ty);
    bus.i_end        = e;
    bus.i_m_ready    = rdy;

    if (!i_rst_n) begin
      q.delete();
      acc_dx = 0; acc_dy = 0; acc_cnt = 0; acc_drop = 0;
      held_dx = 0; held_dy = 0; held_cnt = 0; held_drop = 0;
    end else begin
      mdx = tx - sx;
      mdy = ty - sy;
      acc = v && (mdx <= 200) && (mdx >= -200) && (mdy <= 200) && (mdy >= -200);
      pop = rdy && (q.size() != 0);
      if (pop) void'(q.pop_front());
      if (acc) begin
        acc_dx += mdx;
        acc_dy += mdy;
        if (acc_cnt < 1023) acc_cnt++;
        if (q.size() < 64) begin
          ent = '{x: tx, y: ty, dx: mdx, dy: mdy};
          q.push_back(ent);
        end else if (acc_drop < 1023) acc_drop++;
      end
      if (e) begin
        held_dx = acc_dx; held_dy = acc_dy; held_cnt = acc_cnt; held_drop = acc_drop;
        acc_dx = 0; acc_dy = 0; acc_cnt = 0; acc_drop = 0;
        pend = 1;
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle(input bit e, input bit rdy);
    tick(0, 0, 0, 0, 0, e, rdy);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{sx: 100, sy: 50,   tx: 110,  ty: 40,  edx: 10,    edy: -10,  acc: 1};
    vecs[1] = '{sx: 0,   sy: 0,    tx: 201,  ty: 0,   edx: 201,   edy: 0,    acc: 0};
    vecs[2] = '{sx: 0,   sy: 0,    tx: 200,  ty: 0,   edx: 200,   edy: 0,    acc: 1};
    vecs[3] = '{sx: 300, sy: 300,  tx: 100,  ty: 500, edx: -200,  edy: 200,  acc: 1};
    vecs[4] = '{sx: 300, sy: 300,  tx: 99,   ty: 300, edx: -201,  edy: 0,    acc: 0};
    vecs[5] = '{sx: 5,   sy: 900,  tx: 5,    ty: 699, edx: 0,     edy: -201, acc: 0};
    vecs[6] = '{sx: 1023,sy: 0,    tx: 1023, ty: 0,   edx: 0,     edy: 0,    acc: 1};
    vecs[7] = '{sx: 1023,sy: 1023, tx: 0,    ty: 0,   edx: -1023, edy: -1023,acc: 0};

    bus.i_valid = 0; bus.i_end = 0; bus.i_m_ready = 0;
    bus.i_src_coor_x = '0; bus.i_src_coor_y = '0;
    bus.i_dst_coor_x = '0; bus.i_dst_coor_y = '0;
    i_rst_n = 0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1;
    chk("rst_m_valid", int'(bus.o_m_valid), 0);
    chk("rst_stat_valid", int'(bus.o_stat_valid), 0);
    chk("rst_count", int'(bus.o_count), 0);
    chk("rst_sum_dx", int'($signed(bus.o_sum_dx)), 0);

    // Single pair then close
    tick(1, 100, 50, 110, 40, 0, 0);
    chk("p1_dx", int'($signed(bus.o_m_dx)), 10);
    chk("p1_dy", int'($signed(bus.o_m_dy)), -10);
    idle(1, 0);
    chk("p1_stat", int'(bus.o_stat_valid), 1);
    chk("p1_sum_dx", int'($signed(bus.o_sum_dx)), 10);
    chk("p1_sum_dy", int'($signed(bus.o_sum_dy)), -10);
    chk("p1_count", int'(bus.o_count), 1);
    chk("p1_drop", int'(bus.o_drop), 0);
    idle(0, 1);

    // Vector table: reject boundary and extremes, each drained afterwards
    foreach (vecs[i]) begin
      tick(1, vecs[i].sx, vecs[i].sy, vecs[i].tx, vecs[i].ty, 0, 0);
      chk($sformatf("vec%0d_valid", i), int'(bus.o_m_valid), int'(vecs[i].acc));
      if (vecs[i].acc) begin
        chk($sformatf("vec%0d_dx", i), int'($signed(bus.o_m_dx)), vecs[i].edx);
        chk($sformatf("vec%0d_dy", i), int'($signed(bus.o_m_dy)), vecs[i].edy);
        idle(0, 1);
      end
    end
    idle(1, 0);
    chk("tbl_count", int'(bus.o_count), 4);
    chk("tbl_sum_dx", int'($signed(bus.o_sum_dx)), 10);
    chk("tbl_sum_dy", int'($signed(bus.o_sum_dy)), 190);

    // Overfill: 70 accepted pairs with no consumer
    for (int i = 0; i < 70; i++)
      tick(1, 20 + i * 3, 500, 20 + i * 3 + (i % 21) - 10, 500 + (i % 5) - 2, 0, 0);
    idle(1, 0);
    chk("ovf_count", int'(bus.o_count), 70);
    chk("ovf_drop", int'(bus.o_drop), 6);

    // Full FIFO with pop and push in the same cycle
    tick(1, 5, 5, 8, 9, 0, 1);
    idle(1, 0);
    chk("full_pp_count", int'(bus.o_count), 1);
    chk("full_pp_drop", int'(bus.o_drop), 0);
    chk("full_pp_sum_dy", int'($signed(bus.o_sum_dy)), 4);
    for (int i = 0; i < 64; i++) idle(0, 1);
    chk("drained", int'(bus.o_m_valid), 0);

    // Pair coincident with close, then back-to-back close
    tick(1, 10, 10, 13, 10, 1, 0);
    chk("co_stat", int'(bus.o_stat_valid), 1);
    chk("co_count", int'(bus.o_count), 1);
    chk("co_sum_dx", int'($signed(bus.o_sum_dx)), 3);
    idle(1, 0);
    chk("b2b_stat", int'(bus.o_stat_valid), 1);
    chk("b2b_count", int'(bus.o_count), 0);
    chk("b2b_sum_dx", int'($signed(bus.o_sum_dx)), 0);
    idle(0, 1);
    idle(0, 0);

    // Reset with entries buffered and an i_end in the reset cycle
    for (int i = 0; i < 5; i++) tick(1, 50 + i, 60, 40 + i, 70, 0, 0);
    idle(1, 0);
    i_rst_n = 0;
    tick(1, 1, 1, 2, 2, 1, 0);
    i_rst_n = 1;
    chk("rst2_m_valid", int'(bus.o_m_valid), 0);
    chk("rst2_stat", int'(bus.o_stat_valid), 0);
    chk("rst2_sum_dx", int'($signed(bus.o_sum_dx)), 0);
    chk("rst2_sum_dy", int'($signed(bus.o_sum_dy)), 0);
    chk("rst2_count", int'(bus.o_count), 0);
    chk("rst2_drop", int'(bus.o_drop), 0);
    idle(0, 1);
    idle(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
